// File: rtl/carry_pipe_arbiter.sv
// Two-requester arbiter/sequencer for the pipelined carry adder; tags follow each op to steer results back.
// Define CARRY_ARB_FIXED_PRIO_EN for strict requester-0 priority instead of round-robin.
module carry_pipe_arbiter #(
  parameter int W   = 32,
  parameter int LAT = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req0_cin,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic         req1_cin,
  output logic [W-1:0] add_a,
  output logic [W-1:0] add_b,
  output logic         add_cin,
  input  logic [W-1:0] add_s,
  input  logic         add_cout,
  output logic         rsp0_valid,
  output logic         rsp1_valid,
  output logic [W-1:0] rsp_s,
  output logic         rsp_cout,
  output logic         busy
);

  // Handshake: a request is accepted at a rising edge where reqN_valid and
  // reqN_ready are both high; ready never rises without valid, and at most
  // one ready is high per cycle. Responses are single-cycle, unstallable.
  logic         gnt0;
  logic         gnt1;
  logic         hs;
  logic         hs_id;
  logic [LAT:0] tag_v;
  logic [LAT:0] tag_id;

`ifdef CARRY_ARB_FIXED_PRIO_EN
  always_comb begin
    gnt0 = req0_valid;
    gnt1 = req1_valid & ~req0_valid;
  end
`else
  logic last_grant;

  // On contention the requester not granted most recently wins.
  always_comb begin
    gnt0 = req0_valid & (~req1_valid | last_grant);
    gnt1 = req1_valid & (~req0_valid | ~last_grant);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (hs) begin
      last_grant <= hs_id;
    end
  end
`endif

  assign req0_ready = gnt0 & rst_n;
  assign req1_ready = gnt1 & rst_n;
  assign hs         = (req0_valid & req0_ready) | (req1_valid & req1_ready);
  assign hs_id      = req1_valid & req1_ready;

  // Idle cycles feed 0+0+0 so the adder never sees stale operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      add_a   <= '0;
      add_b   <= '0;
      add_cin <= 1'b0;
      tag_v   <= '0;
      tag_id  <= '0;
    end else begin
      if (hs) begin
        add_a   <= hs_id ? req1_a   : req0_a;
        add_b   <= hs_id ? req1_b   : req0_b;
        add_cin <= hs_id ? req1_cin : req0_cin;
      end else begin
        add_a   <= '0;
        add_b   <= '0;
        add_cin <= 1'b0;
      end
      tag_v  <= {tag_v[LAT-1:0], hs};
      tag_id <= {tag_id[LAT-1:0], hs_id};
    end
  end

  assign rsp0_valid = tag_v[LAT] & ~tag_id[LAT];
  assign rsp1_valid = tag_v[LAT] & tag_id[LAT];
  assign rsp_s      = add_s;
  assign rsp_cout   = add_cout;
  assign busy       = |tag_v;

endmodule

// File: tb/tb_carry_pipe_arbiter.sv
// Bench for carry_pipe_arbiter with a behavioural LAT-deep adder; expected responses go through a queue.
module tb_carry_pipe_arbiter;
  localparam int W   = 32;
  localparam int LAT = 2;
  localparam int EW  = 16 + 2 + W;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req0_ready, req0_cin;
  logic         req1_valid, req1_ready, req1_cin;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [W-1:0] add_a, add_b, add_s;
  logic         add_cin, add_cout;
  logic         rsp0_valid, rsp1_valid, rsp_cout, busy;
  logic [W-1:0] rsp_s;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [EW-1:0] exp_q[$];
  logic [W-1:0]  exp0_s, exp1_s;
  logic          exp0_c, exp1_c;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  carry_pipe_arbiter #(.W(W), .LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_s(add_s), .add_cout(add_cout),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_s(rsp_s), .rsp_cout(rsp_cout), .busy(busy)
  );

  // Behavioural adder: LAT register stages, no reset (keeps stale data).
  logic [W:0] apipe [LAT];
  always @(posedge clk) begin
    apipe[0] <= {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};
    for (int i = 1; i < LAT; i++) apipe[i] <= apipe[i-1];
  end
  assign {add_cout, add_s} = apipe[LAT-1];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor pops on every response; observer pushes on every handshake.
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (rsp0_valid && rsp1_valid) check("rsp_both_valid", 1, 0);
      if (rsp0_valid || rsp1_valid) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", {rsp1_valid, rsp0_valid}, 0);
        end else begin
          e = exp_q.pop_front();
          check("rsp_cycle", cyc, e[EW-1 -: 16]);
          check("rsp_id", rsp1_valid, e[W+1]);
          check("rsp_cout", rsp_cout, e[W]);
          check("rsp_s", rsp_s, e[W-1:0]);
        end
      end
      if (req0_valid && req0_ready) exp_q.push_back({16'(cyc + LAT + 1), 1'b0, exp0_c, exp0_s});
      if (req1_valid && req1_ready) exp_q.push_back({16'(cyc + LAT + 1), 1'b1, exp1_c, exp1_s});
    end
  end

  task automatic drive0(input logic v, input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input logic [W-1:0] es, input logic ec);
    req0_valid = v; req0_a = a; req0_b = b; req0_cin = c; exp0_s = es; exp0_c = ec;
  endtask

  task automatic drive1(input logic v, input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input logic [W-1:0] es, input logic ec);
    req1_valid = v; req1_a = a; req1_b = b; req1_cin = c; exp1_s = es; exp1_c = ec;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    next_cycle();
    rst_n = 1'b0;
    @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_ready0", req0_ready, 0);
    check("reset_ready1", req1_ready, 0);
    next_cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive0(1, 32'h3, 32'h3, 1, 32'h7, 0);
    drive1(1, 32'h5, 32'h5, 0, 32'ha, 0);
    // Reset held with both requesters valid
    repeat (3) next_cycle();
    @(negedge clk);
    check("rst_ready0", req0_ready, 0);
    check("rst_ready1", req1_ready, 0);
    check("rst_add_a", add_a, 0);
    check("rst_add_b", add_b, 0);
    check("rst_add_cin", add_cin, 0);
    check("rst_busy", busy, 0);
    next_cycle();
    drive0(0, 0, 0, 0, 0, 0);
    drive1(0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    next_cycle();

    // Single operation: 3+3+1
    drive0(1, 32'h3, 32'h3, 1, 32'h7, 0);
    @(negedge clk);
    check("single_ready0", req0_ready, 1);
    check("single_busy_c", busy, 0);
    next_cycle();
    drive0(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("single_add_a", add_a, 32'h3);
    check("single_add_cin", add_cin, 1);
    for (int k = 1; k <= 3; k++) begin
      if (k > 1) begin next_cycle(); @(negedge clk); end
      check("single_busy", busy, 1);
    end
    next_cycle();
    @(negedge clk);
    check("single_busy_end", busy, 0);

    // Contention after a fresh reset: 0,1,0,1
    do_reset();
    drive0(1, 32'h7, 32'h7, 1, 32'hf, 0);
    drive1(1, 32'hffffffff, 32'h1, 0, 32'h0, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("cont_ready0", req0_ready, (i % 2) == 0);
      check("cont_ready1", req1_ready, (i % 2) == 1);
      next_cycle();
    end
    drive0(0, 0, 0, 0, 0, 0);
    drive1(0, 0, 0, 0, 0, 0);
    repeat (5) next_cycle();

    // Back-to-back from requester 0
    for (int i = 1; i <= 4; i++) begin
      drive0(1, W'(i), 0, 0, W'(i), 0);
      @(negedge clk);
      check("b2b_ready0", req0_ready, 1);
      next_cycle();
    end
    drive0(0, 0, 0, 0, 0, 0);
    repeat (6) next_cycle();
    check("b2b_drained", exp_q.size(), 0);

    // Reset while two operations are in flight
    drive1(1, 32'h5, 32'h6, 0, 32'hb, 0);
    next_cycle();
    drive1(0, 0, 0, 0, 0, 0);
    drive0(1, 32'h9, 32'h9, 0, 32'h12, 0);
    next_cycle();
    drive0(0, 0, 0, 0, 0, 0);
    check("midrst_busy_before", busy, 1);
    do_reset();
    @(negedge clk);
    check("midrst_busy_after", busy, 0);
    repeat (6) next_cycle();

`ifdef CARRY_ARB_FIXED_PRIO_EN
    drive0(1, 32'h1, 32'h1, 0, 32'h2, 0);
    drive1(1, 32'h2, 32'h2, 0, 32'h4, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("prio_ready0", req0_ready, 1);
      check("prio_ready1", req1_ready, 0);
      next_cycle();
    end
    drive0(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("prio_ready1_rise", req1_ready, 1);
    next_cycle();
    drive1(0, 0, 0, 0, 0, 0);
`else
    drive0(1, 32'h1, 32'h1, 0, 32'h2, 0);
    drive1(1, 32'h2, 32'h2, 1, 32'h5, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rr_ready0", req0_ready, (i % 2) == 0);
      check("rr_ready1", req1_ready, (i % 2) == 1);
      next_cycle();
    end
    drive0(0, 0, 0, 0, 0, 0);
    drive1(0, 0, 0, 0, 0, 0);
`endif
    repeat (6) next_cycle();
    check("final_drained", exp_q.size(), 0);
    check("final_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/carry_pipe_arbiter.md
# carry_pipe_arbiter

Two-requester arbiter and sequencer for the shared pipelined 32-bit carry adder (`carry_pipe`). It accepts add operations from two clients over valid/ready handshakes and issues at most one operation per cycle into the adder. Each in-flight operation carries a requester tag down a shadow pipeline that matches the adder's depth, so every result is steered back to its originator. It sits between the execution clients and the adder instance and owns the adder's input registers.

## Interface

Parameters:
- `W`, default 32: operand/sum width.
- `LAT`, default 2: adder pipeline depth in clock edges from its input to `add_s`/`add_cout`; must be ≥ 1.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req0_valid` / `req1_valid`  in  1  requester has an operation pending.
- `req0_ready` / `req1_ready`  out  1  grant; a handshake completes when valid and ready are both high at a rising edge.
- `req0_a`, `req0_b` / `req1_a`, `req1_b`  in  W  operands.
- `req0_cin` / `req1_cin`  in  1  carry-in.
- `add_a`, `add_b`  out  W  registered operands to the adder.
- `add_cin`  out  1  registered carry-in to the adder.
- `add_s`  in  W  sum from the adder.
- `add_cout`  in  1  carry-out from the adder.
- `rsp0_valid` / `rsp1_valid`  out  1  result on the shared response bus belongs to requester 0 / 1; single-cycle pulse; no backpressure.
- `rsp_s`  out  W  result sum (equals `add_s`).
- `rsp_cout`  out  1  result carry (equals `add_cout`).
- `busy`  out  1  at least one operation is in flight.

## Operation

- **Arbitration** (combinational from `reqN_valid` and the priority pointer): grants at most one requester per cycle.
  - Only one requester valid: that requester is granted.
  - Both valid: the requester not granted most recently wins (round-robin).
  - `reqN_ready` is 0 when `reqN_valid` is 0.
- **Pointer:** `last_grant` updates only on a completed handshake.
- **Issue registers:**
  - On a handshake, `add_a`/`add_b`/`add_cin` load the granted operands.
  - With no handshake, they load 0, so an idle adder always sees 0+0+0.
- **Tag pipeline:** a shift register of depth LAT+1 entries, each holding {valid, id}.
  - Stage 0 loads {handshake, granted id} at the same edge as the issue registers.
  - Each edge shifts every entry one stage.
  - The last stage is aligned with the cycle in which `add_s` holds that operation's result.
- **Response:**
  - `rsp0_valid = tag_last.valid & ~tag_last.id`.
  - `rsp1_valid = tag_last.valid & tag_last.id`.
  - `rsp_s`/`rsp_cout` pass through combinationally from the adder.
- **Arithmetic:** `{rsp_cout, rsp_s} = a + b + cin`, computed by the adder modulo 2^(W+1). The arbiter never modifies data.
- **Busy:** `busy` = OR of all tag valid bits.
- **Ordering:** results return in issue order. Both requesters may have operations interleaved in flight.
- **Reset:**
  - Asserting `rst_n` clears issue registers, tag valids, and sets `last_grant = 1`, so requester 0 wins the first contention.
  - Reset mid-operation discards every in-flight operation; no `rsp*_valid` is produced for them, even though the adder keeps stale data.

## Timing

- Handshake in cycle c: the adder inputs hold the operation during cycle c+1; the response is valid during cycle c+LAT+1.
- Latency is LAT+1 cycles (default 3) from handshake to response.
- Throughput: one operation per cycle sustained; no bubbles under back-to-back requests.
- Outputs during reset and until first handshake:
  - `reqN_ready` follows arbitration (combinational), 0 while `rst_n` is low.
  - `add_a = 0`, `add_b = 0`, `add_cin = 0`.
  - `rsp0_valid = 0`, `rsp1_valid = 0`, `busy = 0`.
  - `rsp_s`/`rsp_cout` mirror the adder and are don't-care while both `rsp*_valid` are low.
- Simultaneous events: a new grant and a response in the same cycle are independent and both proceed.

## Configuration

- Macro `CARRY_ARB_FIXED_PRIO_EN`.
- **Defined:** requester 0 has strict priority; requester 1 is granted only when `req0_valid` is 0. `last_grant` is not implemented.
- **Undefined (default):** round-robin as described above.

## Test plan

1. **Reset:** hold `rst_n` low with both `reqN_valid=1` -> `req0_ready=req1_ready=0`, `add_a=0`, `busy=0`, no `rsp*_valid` pulses.
2. **Single operation:** `req0` a=0x3, b=0x3, cin=1 for one cycle (LAT=2) -> `req0_ready=1` that cycle; exactly 3 cycles later `rsp0_valid=1`, `rsp_s=0x7`, `rsp_cout=0`; `busy` high for cycles c+1..c+3.
3. **Contention:** both valid continuously; `req0` a=0x7, b=0x7, cin=1; `req1` a=0xFFFFFFFF, b=0x1, cin=0.
   - Grants alternate 0,1,0,1 starting with 0.
   - `rsp0` returns s=0xF, cout=0; `rsp1` returns s=0x0, cout=1.
   - Responses alternate in the same order.
4. **Back-to-back:** `req0` issues a=1,2,3,4 with b=0, cin=0 on 4 consecutive cycles -> `rsp0_valid` high on 4 consecutive cycles with `rsp_s`=1,2,3,4 in order.
5. **Reset mid-flight:** issue 2 operations, then pulse `rst_n` low for 1 cycle on the next cycle -> no `rsp*_valid` ever asserted for them; `busy=0` immediately.
6. **Fixed priority:** with `CARRY_ARB_FIXED_PRIO_EN` and both valid for 5 cycles -> `req0` granted all 5 cycles; `req1_ready` first rises in the cycle after `req0_valid` drops.
